class_select_unit: RTL

//   Consumes the Q8.8 probability vector produced by the softmax stage and resolves it
//   to a single predicted class. Output: index, confidence value and a low-confidence flag.

---
 rtl/class_select_unit_if.sv | 32 +++
 rtl/class_select_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/class_select_unit_if.sv
// Handshake and result bundle for class_select_unit: probability frame in, argmax result out.
// master = upstream/downstream side, slave = the selection unit.
interface class_select_unit_if #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
);
  logic [N_CLASSES*DATA_W-1:0] prob_in;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           conf_thresh;
  logic [IDX_W-1:0]            class_idx;
  logic [DATA_W-1:0]           class_conf;
  logic                        low_conf;
  logic [IDX_W-1:0]            class2_idx;
  logic [DATA_W-1:0]           margin;
  logic                        out_valid;
  logic                        out_ready;
  logic [15:0]                 frame_count;

  modport master (
    output prob_in, in_valid, conf_thresh, out_ready,
    input  in_ready, class_idx, class_conf, low_conf, class2_idx, margin,
           out_valid, frame_count
  );

  modport slave (
    input  prob_in, in_valid, conf_thresh, out_ready,
    output in_ready, class_idx, class_conf, low_conf, class2_idx, margin,
           out_valid, frame_count
  );
endinterface

// File: rtl/class_select_unit.sv
// Sequential argmax over a latched Q8.8 probability frame, one class per cycle.
// Optional runner-up/margin tracking is enabled by defining TOP2_EN.
module class_select_unit #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
) (
  input logic                 clk,
  input logic                 rst,
  class_select_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t state, state_nxt;

  logic [N_CLASSES-1:0][DATA_W-1:0] prob_q;
  logic [DATA_W-1:0]                thresh_q;
  logic [DATA_W-1:0]                best_q, best_nxt, entry;
  logic [IDX_W-1:0]                 best_idx_q, best_idx_nxt, cnt_q;
  logic                             accept, last, out_hs;
  logic                             in_ready, out_valid;

  logic [IDX_W-1:0]  class_idx_q;
  logic [DATA_W-1:0] class_conf_q;
  logic              low_conf_q;
  logic [15:0]       frame_count_q;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (state == SCAN) && (cnt_q == IDX_W'(N_CLASSES - 1));
  assign out_hs = (state == HOLD) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (last)   state_nxt = HOLD;
      HOLD:    if (out_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags decode the state register only, so out_ready never reaches in_ready.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  assign entry = prob_q[cnt_q];

  always_comb begin
    best_nxt     = best_q;
    best_idx_nxt = best_idx_q;
    if (entry > best_q) begin
      best_nxt     = entry;
      best_idx_nxt = cnt_q;
    end
  end

`ifdef TOP2_EN
  logic [DATA_W-1:0] second_q, second_nxt;
  logic [IDX_W-1:0]  second_idx_q, second_idx_nxt;
  logic              second_vld_q, second_vld_nxt;
  logic [IDX_W-1:0]  class2_idx_q;
  logic [DATA_W-1:0] margin_q;

  // Entry 0 only seeds best; the runner-up slot fills from entry 1 onward, so a
  // single-class frame keeps runner-up 0 and margin equals class_conf.
  always_comb begin
    second_nxt     = second_q;
    second_idx_nxt = second_idx_q;
    second_vld_nxt = second_vld_q;
    if (cnt_q != '0) begin
      if (entry > best_q) begin
        second_nxt     = best_q;
        second_idx_nxt = best_idx_q;
        second_vld_nxt = 1'b1;
      end else if (!second_vld_q || entry > second_q) begin
        second_nxt     = entry;
        second_idx_nxt = cnt_q;
        second_vld_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      second_q     <= '0;
      second_idx_q <= '0;
      second_vld_q <= 1'b0;
    end else if (state == SCAN) begin
      second_q     <= second_nxt;
      second_idx_q <= second_idx_nxt;
      second_vld_q <= second_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class2_idx_q <= '0;
      margin_q     <= '0;
    end else if (last) begin
      class2_idx_q <= second_idx_nxt;
      margin_q     <= best_nxt - second_nxt;
    end
  end

  assign bus.class2_idx = class2_idx_q;
  assign bus.margin     = margin_q;
`else
  assign bus.class2_idx = '0;
  assign bus.margin     = '0;
`endif

  // NOTE: frame and scan registers are left unreset; every accept reinitialises them
  // before they are read, so only control state and visible results take rst.
  always_ff @(posedge clk) begin
    if (accept) begin
      prob_q     <= bus.prob_in;
      thresh_q   <= bus.conf_thresh;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
    end else if (state == SCAN) begin
      best_q     <= best_nxt;
      best_idx_q <= best_idx_nxt;
      cnt_q      <= cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      class_idx_q  <= '0;
      class_conf_q <= '0;
      low_conf_q   <= 1'b0;
    end else if (last) begin
      class_idx_q  <= best_idx_nxt;
      class_conf_q <= best_nxt;
      low_conf_q   <= (best_nxt < thresh_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         frame_count_q <= '0;
    else if (out_hs) frame_count_q <= frame_count_q + 16'd1;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.class_idx   = class_idx_q;
  assign bus.class_conf  = class_conf_q;
  assign bus.low_conf    = low_conf_q;
  assign bus.frame_count = frame_count_q;

endmodule
